// File: rtl/syn_gpu_pkg.sv
// rtl/syn_gpu_pkg.sv - GPU pixel types and BT.709 YCbCr->RGB coefficient constants
package syn_gpu_pkg;

  localparam int P_LUM_W   = 4;
  localparam int P_CHRM_W  = 2;
  localparam int P_RGB_RES = 4;
  localparam int P_RGB_MAX = (1 << P_RGB_RES) - 1;

  typedef struct packed {
    logic [P_LUM_W-1:0]  y;
    logic [P_CHRM_W-1:0] cb;
    logic [P_CHRM_W-1:0] cr;
  } pxl_ycbcr_t;

  typedef struct packed {
    logic [P_RGB_RES-1:0] red;
    logic [P_RGB_RES-1:0] green;
    logic [P_RGB_RES-1:0] blue;
  } pxl_rgb_t;

  // BT.709 coefficients in the 8-bit video domain
  localparam real C_Y    = 1.164;
  localparam real C_R_CR = 1.793;
  localparam real C_G_CB = 0.213;
  localparam real C_G_CR = 0.533;
  localparam real C_B_CB = 2.112;

  // Narrow codes expand to 8-bit video range: luma step 219/15, chroma step 224/3;
  // the 8-bit result folds back to 4 bits by a divide of 16.
  localparam real S_LUM      = 14.6;
  localparam real S_CHRM     = 74.66667;
  localparam real S_OUT      = 16.0;
  localparam real C_CHRM_OFS = 112.0;

endpackage

// File: rtl/syn_ycbcr2rgb_chan_clamp.sv
// rtl/syn_ycbcr2rgb_chan_clamp.sv - one colour channel: clamp stage (S2) and round stage (S3)
module syn_ycbcr2rgb_chan_clamp
  import syn_gpu_pkg::*;
#(
  parameter int P_FRAC_W = 8,
  parameter int P_ACC_W  = 15
) (
  input  logic                      clk_ir,
  input  logic                      rst_il,
  input  logic                      en_i,
  input  logic signed [P_ACC_W-1:0] sum_i,
  output logic                      sat_o,
  output logic [P_RGB_RES-1:0]      chan_o
);

  localparam logic signed [P_ACC_W-1:0] C_MAX  = P_ACC_W'(P_RGB_MAX << P_FRAC_W);
  localparam logic        [P_ACC_W-1:0] C_HALF = P_ACC_W'(1 << (P_FRAC_W - 1));

  logic        [P_ACC_W-1:0]   clamped_d, clamped_q;
  logic        [P_RGB_RES-1:0] chan_d, chan_q;
  logic                        lo, hi;
  logic        [P_ACC_W-1:0]   rnd;

  always_comb begin
    lo        = sum_i < 0;
    hi        = sum_i > C_MAX;
    sat_o     = lo | hi;
    rnd       = clamped_q + C_HALF;
    clamped_d = clamped_q;
    chan_d    = chan_q;
    if (en_i) begin
      clamped_d = lo ? '0 : (hi ? C_MAX : sum_i);
      chan_d    = P_RGB_RES'(rnd >> P_FRAC_W);
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      clamped_q <= '0;
      chan_q    <= '0;
    end else begin
      clamped_q <= clamped_d;
      chan_q    <= chan_d;
    end
  end

  assign chan_o = chan_q;

endmodule

// File: rtl/syn_ycbcr2rgb_conv.sv
// rtl/syn_ycbcr2rgb_conv.sv - 3-stage BT.709 YCbCr->RGB converter, valid/ready both sides
// Optional saturation statistics: SYN_YCBCR2RGB_STATS_EN
module syn_ycbcr2rgb_conv
  import syn_gpu_pkg::*;
#(
  parameter int P_FRAC_W = 8,
  parameter int P_ACC_W  = 15
) (
  input  logic       clk_ir,
  input  logic       rst_il,
  input  logic       ycbcr_valid_i,
  output logic       ycbcr_ready_o,
  input  pxl_ycbcr_t ycbcr_pxl_i,
  input  logic       ycbcr_eof_i,
  output logic       rgb_valid_o,
  input  logic       rgb_ready_i,
  output pxl_rgb_t   rgb_pxl_o,
  output logic       rgb_eof_o
`ifdef SYN_YCBCR2RGB_STATS_EN
  ,
  input  logic        sat_cnt_clr_i,
  output logic [15:0] sat_cnt_o
`endif
);

  localparam real C_ONE = real'(1 << P_FRAC_W);

  localparam int KY_I   = int'(C_Y * S_LUM / S_OUT * C_ONE);
  localparam int KRCR_I = int'(C_R_CR * S_CHRM / S_OUT * C_ONE);
  localparam int KGCB_I = int'(C_G_CB * S_CHRM / S_OUT * C_ONE);
  localparam int KGCR_I = int'(C_G_CR * S_CHRM / S_OUT * C_ONE);
  localparam int KBCB_I = int'(C_B_CB * S_CHRM / S_OUT * C_ONE);
  localparam int OR_I   = int'(-C_R_CR * C_CHRM_OFS / S_OUT * C_ONE);
  localparam int OG_I   = int'((C_G_CB + C_G_CR) * C_CHRM_OFS / S_OUT * C_ONE);
  localparam int OB_I   = int'(-C_B_CB * C_CHRM_OFS / S_OUT * C_ONE);

  localparam logic signed [P_ACC_W-1:0] KY   = P_ACC_W'(KY_I);
  localparam logic signed [P_ACC_W-1:0] KRCR = P_ACC_W'(KRCR_I);
  localparam logic signed [P_ACC_W-1:0] KGCB = P_ACC_W'(KGCB_I);
  localparam logic signed [P_ACC_W-1:0] KGCR = P_ACC_W'(KGCR_I);
  localparam logic signed [P_ACC_W-1:0] KBCB = P_ACC_W'(KBCB_I);
  localparam logic signed [P_ACC_W-1:0] K_OR = P_ACC_W'(OR_I);
  localparam logic signed [P_ACC_W-1:0] K_OG = P_ACC_W'(OG_I);
  localparam logic signed [P_ACC_W-1:0] K_OB = P_ACC_W'(OB_I);

  logic en;

  logic signed [P_ACC_W-1:0] y_s, cb_s, cr_s;
  logic signed [P_ACC_W-1:0] py_d, pcr_r_d, pcb_g_d, pcr_g_d, pcb_b_d;
  logic signed [P_ACC_W-1:0] py_q, pcr_r_q, pcb_g_q, pcr_g_q, pcb_b_q;
  logic                      v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic                      eof1_d, eof1_q, eof2_d, eof2_q, eof3_d, eof3_q;
  logic signed [P_ACC_W-1:0] r_sum, g_sum, b_sum;
  logic                      r_sat, g_sat, b_sat;
  logic [P_RGB_RES-1:0]      r_chan, g_chan, b_chan;

  // A full output register that is not being drained stalls every stage at once.
  assign en            = ~v3_q | rgb_ready_i;
  assign ycbcr_ready_o = en;

  assign y_s  = signed'(P_ACC_W'(ycbcr_pxl_i.y));
  assign cb_s = signed'(P_ACC_W'(ycbcr_pxl_i.cb));
  assign cr_s = signed'(P_ACC_W'(ycbcr_pxl_i.cr));

  always_comb begin
    py_d    = py_q;
    pcr_r_d = pcr_r_q;
    pcb_g_d = pcb_g_q;
    pcr_g_d = pcr_g_q;
    pcb_b_d = pcb_b_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    v3_d    = v3_q;
    eof1_d  = eof1_q;
    eof2_d  = eof2_q;
    eof3_d  = eof3_q;
    if (en) begin
      py_d    = y_s * KY;
      pcr_r_d = cr_s * KRCR;
      pcb_g_d = cb_s * KGCB;
      pcr_g_d = cr_s * KGCR;
      pcb_b_d = cb_s * KBCB;
      v1_d    = ycbcr_valid_i;
      v2_d    = v1_q;
      v3_d    = v2_q;
      eof1_d  = ycbcr_eof_i;
      eof2_d  = eof1_q;
      eof3_d  = eof2_q;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      py_q    <= '0;
      pcr_r_q <= '0;
      pcb_g_q <= '0;
      pcr_g_q <= '0;
      pcb_b_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      v3_q    <= 1'b0;
      eof1_q  <= 1'b0;
      eof2_q  <= 1'b0;
      eof3_q  <= 1'b0;
    end else begin
      py_q    <= py_d;
      pcr_r_q <= pcr_r_d;
      pcb_g_q <= pcb_g_d;
      pcr_g_q <= pcr_g_d;
      pcb_b_q <= pcb_b_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      v3_q    <= v3_d;
      eof1_q  <= eof1_d;
      eof2_q  <= eof2_d;
      eof3_q  <= eof3_d;
    end
  end

  assign r_sum = py_q + pcr_r_q + K_OR;
  assign g_sum = py_q - pcb_g_q - pcr_g_q + K_OG;
  assign b_sum = py_q + pcb_b_q + K_OB;

  syn_ycbcr2rgb_chan_clamp #(.P_FRAC_W(P_FRAC_W), .P_ACC_W(P_ACC_W)) u_r (
    .clk_ir(clk_ir), .rst_il(rst_il), .en_i(en), .sum_i(r_sum), .sat_o(r_sat), .chan_o(r_chan)
  );
  syn_ycbcr2rgb_chan_clamp #(.P_FRAC_W(P_FRAC_W), .P_ACC_W(P_ACC_W)) u_g (
    .clk_ir(clk_ir), .rst_il(rst_il), .en_i(en), .sum_i(g_sum), .sat_o(g_sat), .chan_o(g_chan)
  );
  syn_ycbcr2rgb_chan_clamp #(.P_FRAC_W(P_FRAC_W), .P_ACC_W(P_ACC_W)) u_b (
    .clk_ir(clk_ir), .rst_il(rst_il), .en_i(en), .sum_i(b_sum), .sat_o(b_sat), .chan_o(b_chan)
  );

  assign rgb_valid_o = v3_q;
  assign rgb_eof_o   = eof3_q;
  assign rgb_pxl_o   = '{red: r_chan, green: g_chan, blue: b_chan};

`ifdef SYN_YCBCR2RGB_STATS_EN
  logic        s2_d, s2_q, s3_d, s3_q;
  logic [15:0] cnt_d, cnt_q;

  always_comb begin
    s2_d  = s2_q;
    s3_d  = s3_q;
    cnt_d = cnt_q;
    if (en) begin
      s2_d = r_sat | g_sat | b_sat;
      s3_d = s2_q;
    end
    if (sat_cnt_clr_i) begin
      cnt_d = '0;
    end else if (v3_q && rgb_ready_i && s3_q && cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_ir or negedge rst_il) begin
    if (!rst_il) begin
      s2_q  <= 1'b0;
      s3_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      cnt_q <= cnt_d;
    end
  end

  assign sat_cnt_o = cnt_q;
`else
  logic unused_sat;
  assign unused_sat = r_sat | g_sat | b_sat;
`endif

endmodule

// File: tb/tb_syn_ycbcr2rgb_conv.sv
// tb/tb_syn_ycbcr2rgb_conv.sv - scoreboard bench for syn_ycbcr2rgb_conv
module tb_syn_ycbcr2rgb_conv;
  import syn_gpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ycbcr_valid = 1'b0;
  logic       ycbcr_ready;
  pxl_ycbcr_t ycbcr_pxl = '0;
  logic       ycbcr_eof = 1'b0;
  logic       rgb_valid;
  logic       rgb_ready = 1'b1;
  pxl_rgb_t   rgb_pxl;
  logic       rgb_eof;
`ifdef SYN_YCBCR2RGB_STATS_EN
  logic        sat_clr = 1'b0;
  logic [15:0] sat_cnt;
  logic [15:0] exp_sat = '0;
`endif

  always #5 clk = ~clk;

  syn_ycbcr2rgb_conv dut (
    .clk_ir(clk), .rst_il(rst_n),
    .ycbcr_valid_i(ycbcr_valid), .ycbcr_ready_o(ycbcr_ready),
    .ycbcr_pxl_i(ycbcr_pxl), .ycbcr_eof_i(ycbcr_eof),
    .rgb_valid_o(rgb_valid), .rgb_ready_i(rgb_ready),
    .rgb_pxl_o(rgb_pxl), .rgb_eof_o(rgb_eof)
`ifdef SYN_YCBCR2RGB_STATS_EN
    , .sat_cnt_clr_i(sat_clr), .sat_cnt_o(sat_cnt)
`endif
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic        eof;
    logic        sat;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rand_rdy = 1'b0;

  function automatic exp_t model(input logic [7:0] code, input logic eof);
    int   yi, cbi, cri, v;
    int   s[3];
    exp_t e;
    yi  = int'(code[7:4]);
    cbi = int'(code[3:2]);
    cri = int'(code[1:0]);
    s[0] = yi * 272 + cri * 2142 - 3213;
    s[1] = yi * 272 - cbi * 254 - cri * 637 + 1337;
    s[2] = yi * 272 + cbi * 2523 - 3785;
    e.eof = eof;
    e.sat = 1'b0;
    e.rgb = '0;
    for (int c = 0; c < 3; c++) begin
      v = s[c];
      if (v < 0) begin v = 0; e.sat = 1'b1; end
      else if (v > 3840) begin v = 3840; e.sat = 1'b1; end
      e.rgb[11-4*c -: 4] = 4'((v + 128) >> 8);
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: compares every output handshake and the ready equation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rgb_valid && rgb_ready) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output: got rgb=%h eof=%b with empty scoreboard", rgb_pxl, rgb_eof);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rgb_pxl !== e.rgb || rgb_eof !== e.eof) begin
            n_fail++;
            $display("FAIL pixel: got rgb=%h eof=%b expected rgb=%h eof=%b", rgb_pxl, rgb_eof, e.rgb, e.eof);
          end
`ifdef SYN_YCBCR2RGB_STATS_EN
          if (e.sat && exp_sat != 16'hFFFF) exp_sat = exp_sat + 16'd1;
`endif
        end
      end
      n_tests++;
      if (ycbcr_ready !== (!rgb_valid || rgb_ready)) begin
        n_fail++;
        $display("FAIL ready_eq: got %b expected %b", ycbcr_ready, (!rgb_valid || rgb_ready));
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 rgb_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [7:0] code, input logic eof, input exp_t e);
    ycbcr_pxl   = code;
    ycbcr_eof   = eof;
    ycbcr_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ycbcr_ready) begin
        sb.push_back(e);
        @(posedge clk);
        #1 ycbcr_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_tests++;
    n_fail++;
    $display("FAIL send_timeout: code %h not accepted, ready=%b expected 1", code, ycbcr_ready);
    ycbcr_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int k = 0; k < budget && sb.size() != 0; k++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  exp_t e;
  logic [11:0] frz;

  initial begin
    #1;
    check("reset_valid", 32'(rgb_valid), 32'd0);
    check("reset_pxl", 32'(rgb_pxl), 32'd0);
    check("reset_eof", 32'(rgb_eof), 32'd0);
`ifdef SYN_YCBCR2RGB_STATS_EN
    check("reset_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
    do_reset();

    // Directed vectors with hand-computed results; first one also checks latency.
    e = '{rgb: {4'd0, 4'd5, 4'd0}, eof: 1'b0, sat: 1'b1};
    send(8'h00, 1'b0, e);
    @(negedge clk); check("lat_c1", 32'(rgb_valid), 32'd0);
    @(negedge clk); check("lat_c2", 32'(rgb_valid), 32'd0);
    @(negedge clk); check("lat_c3", 32'(rgb_valid), 32'd1);
    @(posedge clk); #1;
    e = '{rgb: {4'd13, 4'd8, 4'd4}, eof: 1'b1, sat: 1'b0};
    send(8'h86, 1'b1, e);
    e = '{rgb: {4'd15, 4'd11, 4'd15}, eof: 1'b0, sat: 1'b1};
    send(8'hFF, 1'b0, e);
    e = '{rgb: {4'd3, 4'd15, 4'd1}, eof: 1'b0, sat: 1'b1};
    send(8'hF0, 1'b0, e);
    e = '{rgb: {4'd0, 4'd5, 4'd9}, eof: 1'b1, sat: 1'b0};
    send(8'h49, 1'b1, e);
    drain(100);
`ifdef SYN_YCBCR2RGB_STATS_EN
    check("sat_cnt_directed", 32'(sat_cnt), 32'd3);
`endif

    // Exhaustive sweep, back-to-back input, random downstream ready.
    rand_rdy = 1'b1;
    for (int c = 0; c < 256; c++) begin
      send(8'(c), 1'(c & 1), model(8'(c), 1'(c & 1)));
    end
    drain(3000);
    rand_rdy = 1'b0;
    @(posedge clk); #1 rgb_ready = 1'b1;
`ifdef SYN_YCBCR2RGB_STATS_EN
    check("sat_cnt_sweep", 32'(sat_cnt), 32'(exp_sat));
`endif

    // Fill with downstream stalled, hold, then release.
    rgb_ready = 1'b0;
    e = '{rgb: {4'd13, 4'd8, 4'd4}, eof: 1'b1, sat: 1'b0};
    send(8'h86, 1'b1, e);
    e = '{rgb: {4'd0, 4'd5, 4'd9}, eof: 1'b0, sat: 1'b0};
    send(8'h49, 1'b0, e);
    e = '{rgb: {4'd15, 4'd11, 4'd15}, eof: 1'b1, sat: 1'b1};
    send(8'hFF, 1'b1, e);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      frz = rgb_pxl;
      check("stall_valid", 32'(rgb_valid), 32'd1);
      check("stall_pxl", 32'(frz), 32'h0D84);
      check("stall_eof", 32'(rgb_eof), 32'd1);
      check("stall_in_ready", 32'(ycbcr_ready), 32'd0);
    end
    @(posedge clk); #1 rgb_ready = 1'b1;
    drain(100);

    // Reset with two pixels in flight: nothing may emerge afterwards.
    e = '{rgb: {4'd0, 4'd5, 4'd0}, eof: 1'b0, sat: 1'b1};
    send(8'h00, 1'b0, e);
    send(8'hFF, 1'b0, e);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(rgb_valid), 32'd0);
`ifdef SYN_YCBCR2RGB_STATS_EN
    check("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
    exp_sat = '0;
`endif
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_valid", 32'(rgb_valid), 32'd0);

`ifdef SYN_YCBCR2RGB_STATS_EN
    e = '{rgb: {4'd0, 4'd5, 4'd0}, eof: 1'b0, sat: 1'b1};
    for (int k = 0; k < 70000; k++) send(8'h00, 1'b0, e);
    drain(100);
    check("sat_cnt_max", 32'(sat_cnt), 32'h0000FFFF);
    sat_clr = 1'b1;
    @(posedge clk); #1 sat_clr = 1'b0;
    check("sat_cnt_clr", 32'(sat_cnt), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
